// File: rtl/rom_playback_sched_if.sv
// Channel-request, ROM read and output-stream signals of the ROM playback scheduler.
// master = the scheduler, slave = channel controllers / ROM / consumer side.
interface rom_playback_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic              req0, req1;
    logic [ADDR_W-1:0] base0, base1;
    logic [ADDR_W-1:0] len0, len1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ch;
    logic              out_ready;

    modport master (
        input  req0, req1, base0, base1, len0, len1, mem_rdata, out_ready,
        output gnt0, gnt1, done0, done1, mem_en, mem_addr, out_data, out_valid, out_ch
    );

    modport slave (
        output req0, req1, base0, base1, len0, len1, mem_rdata, out_ready,
        input  gnt0, gnt1, done0, done1, mem_en, mem_addr, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/rom_playback_sched.sv
// Round-robin scheduler sharing one synchronous word-ROM between two channels;
// each granted burst is streamed out word by word on a valid/ready port.
module rom_playback_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 10
) (
    input logic                  clk,
    input logic                  rst,
    rom_playback_sched_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHOW, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
    } burst_t;

    state_t            state;
    logic              cur_ch;
    logic              last_ch;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    logic [1:0]        req;
    logic              pick;
    burst_t            sel;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] nxt_addr;

    // Tie goes to the channel that was not served last.
    always_comb begin
        req      = {bus.req1, bus.req0};
        pick     = (req == 2'b11) ? ~last_ch : req[1];
        sel.base = pick ? bus.base1 : bus.base0;
        sel.len  = pick ? bus.len1  : bus.len0;
        start    = (sel.base > LAST) ? '0 : sel.base;
        nxt_addr = (cur_addr == LAST) ? '0 : cur_addr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_ch    <= 1'b0;
            last_ch   <= 1'b1;
            cur_addr  <= '0;
            remaining <= '0;
            gnt       <= '0;
            done      <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            done     <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cur_ch    <= pick;
                        cur_addr  <= start;
                        remaining <= sel.len;
                        gnt       <= pick ? 2'b10 : 2'b01;
                        if (sel.len == '0) begin
                            done  <= pick ? 2'b10 : 2'b01;
                            state <= DONE;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= start;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    out_data  <= bus.mem_rdata;
                    out_valid <= 1'b1;
                    state     <= SHOW;
                end
                SHOW: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        cur_addr  <= nxt_addr;
                        if (remaining == ADDR_W'(1)) begin
                            done  <= cur_ch ? 2'b10 : 2'b01;
                            state <= DONE;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= nxt_addr;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    gnt     <= '0;
                    last_ch <= cur_ch;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.done0     = done[0];
    assign bus.done1     = done[1];
    assign bus.mem_en    = mem_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.out_ch    = cur_ch;
endmodule

// File: tb/tb_rom_playback_sched.sv
// Scoreboard bench for rom_playback_sched: stimulus pushes expected words, ROM
// addresses and done channels; negedge monitors pop and compare.
module tb_rom_playback_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_playback_sched_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    rom_playback_sched #(.DATA_W(32), .ADDR_W(4), .DEPTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM holds its own address as data; synchronous read.
    always @(posedge clk)
        if (bus.mem_en) bus.mem_rdata <= (bus.mem_addr < 4'd10) ? 32'(bus.mem_addr) : 32'hdead_beef;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [32:0] out_q[$];
    int          addr_q[$];
    bit          done_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic push_burst(input bit ch, input int base, input int len);
        int a;
        a = (base >= 10) ? 0 : base;
        for (int i = 0; i < len; i++) begin
            out_q.push_back({ch, 32'(a)});
            addr_q.push_back(a);
            a = (a == 9) ? 0 : a + 1;
        end
        done_q.push_back(ch);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, " gnt"},       {bus.gnt1, bus.gnt0}, 0);
        chk({nm, " done"},      {bus.done1, bus.done0}, 0);
        chk({nm, " mem_en"},    bus.mem_en, 0);
        chk({nm, " mem_addr"},  bus.mem_addr, 0);
        chk({nm, " out_valid"}, bus.out_valid, 0);
        chk({nm, " out_data"},  bus.out_data, 0);
        chk({nm, " out_ch"},    bus.out_ch, 0);
    endtask

    // Raise one request in an IDLE cycle T; check grant at T+1 and done at T+exp_done.
    task automatic burst(input bit ch, input int exp_done, input string nm, output int tv);
        int n;
        int tg;
        bit seen;
        @(posedge clk); #1;
        if (ch) bus.req1 = 1'b1; else bus.req0 = 1'b1;
        n = 0; tg = -1; tv = -1; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (tg < 0 && (ch ? bus.gnt1 : bus.gnt0)) tg = n;
            if (tv < 0 && bus.out_valid) tv = n;
            if (ch ? bus.done1 : bus.done0) seen = 1'b1;
            else n++;
        end
        if (ch) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        chk({nm, " grant cycle"}, tg, 1);
        chk({nm, " done cycle"}, seen ? n : -1, exp_done);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (out_q.size() == 0) chk("out word expected", 0, 1);
            else chk("out ch/data", {bus.out_ch, bus.out_data}, out_q.pop_front());
        end
        if (!rst && bus.mem_en) begin
            if (addr_q.size() == 0) chk("mem_en expected", 0, 1);
            else chk("mem_addr", bus.mem_addr, addr_q.pop_front());
        end
        if (!rst && (bus.done0 || bus.done1)) begin
            chk("done with gnt", {bus.gnt1, bus.gnt0}, {bus.done1, bus.done0});
            if (done_q.size() == 0) chk("done expected", 0, 1);
            else chk("done ch", bus.done1, done_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tv;
        int n;
        int nd;
        bus.req0 = 0; bus.req1 = 0;
        bus.base0 = 0; bus.base1 = 0; bus.len0 = 0; bus.len1 = 0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Three words from address 2.
        bus.base0 = 4'd2; bus.len0 = 4'd3;
        push_burst(0, 2, 3);
        burst(0, 10, "t1", tv);
        chk("t1 first out_valid", tv, 3);

        // Zero-length burst: grant and done together, nothing fetched.
        bus.base0 = 4'd4; bus.len0 = 4'd0;
        push_burst(0, 4, 0);
        burst(0, 1, "len0", tv);
        chk("len0 out_valid", tv, -1);
        @(negedge clk);
        chk("len0 idle gnt", {bus.gnt1, bus.gnt0}, 0);

        // Wrapping bursts on channel 1.
        bus.base1 = 4'd8; bus.len1 = 4'd4;
        push_burst(1, 8, 4);
        burst(1, 13, "wrap4", tv);
        bus.len1 = 4'd12;
        push_burst(1, 8, 12);
        burst(1, 37, "wrap12", tv);

        // Back-pressure: first word held for five cycles.
        bus.base0 = 4'd3; bus.len0 = 4'd2;
        push_burst(0, 3, 2);
        bus.out_ready = 1'b0;
        @(posedge clk); #1; bus.req0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 3) chk("stall hold", {bus.out_valid, bus.out_ch, bus.out_data}, {1'b1, 1'b0, 32'd3});
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        n = 8;
        while (n < 300) begin
            @(negedge clk);
            if (bus.done0) break;
            n++;
        end
        bus.req0 = 1'b0;
        chk("stall done cycle", n, 12);

        // Reset during the second word of a five-word burst.
        bus.base0 = 4'd0; bus.len0 = 4'd5;
        push_burst(0, 0, 5);
        @(posedge clk); #1; bus.req0 = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; bus.req0 = 1'b0;
        out_q.delete(); addr_q.delete(); done_q.delete();
        @(negedge clk);
        check_reset("midburst reset");
        rst = 1'b0;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) nd++;
        end
        chk("no done after reset", nd, 0);

        // Simultaneous held requests: ch0 first, then alternate.
        bus.base0 = 4'd5; bus.len0 = 4'd1;
        bus.base1 = 4'd6; bus.len1 = 4'd1;
        push_burst(0, 5, 1); push_burst(1, 6, 1);
        push_burst(0, 5, 1); push_burst(1, 6, 1);
        @(posedge clk); #1; bus.req0 = 1'b1; bus.req1 = 1'b1;
        n = 0; nd = 0;
        while (nd < 4 && n < 200) begin
            @(negedge clk);
            if (n == 1) chk("tie gnt", {bus.gnt1, bus.gnt0}, 2'b01);
            if (bus.done0 || bus.done1) nd++;
            n++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("tie bursts", nd, 4);
        chk("tie span", n, 20);

        repeat (5) @(negedge clk);
        chk("out queue drained", out_q.size(), 0);
        chk("addr queue drained", addr_q.size(), 0);
        chk("done queue drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
